cb_exec: RTL and testbench

//  Executes one CB-prefixed SM83 opcode: shift/rotate group, BIT, RES, SET.

---
 rtl/cb_exec.sv | 148 ++++++++++++++
 tb/tb_cb_exec.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cb_exec.sv
// Executes one CB-prefixed SM83 opcode (shift/rotate, BIT, RES, SET) on a register
// or on memory at (HL), using the external ALU for the shift/rotate group.
module cb_exec (
   input  logic        clk,
   input  logic        rst,
   input  logic        cb_valid,
   input  logic [7:0]  cb_opcode,
   output logic        cb_ready,
   output logic        done,
   output logic [2:0]  reg_sel,
   input  logic [7:0]  reg_rdata,
   output logic        reg_we,
   output logic [7:0]  reg_wdata,
   input  logic [15:0] hl,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack,
   output logic [3:0]  alu_op,
   output logic [7:0]  alu_lhs,
   input  logic [7:0]  alu_r,
   input  logic [3:0]  alu_flags,
   input  logic [3:0]  flags_in,
   output logic        flags_we,
   output logic [3:0]  flags_out
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REG_RD = 3'd1,
      MEM_RD = 3'd2,
      EXEC   = 3'd3,
      MEM_WR = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_op;
   logic [7:0]  r_operand;
   logic [7:0]  r_result;
   logic [15:0] r_addr;

   logic [1:0]  w_grp;
   logic [2:0]  w_bitno;
   logic        w_is_mem;
   logic [7:0]  w_mask;
   logic [7:0]  w_result;
   logic        w_accept;

   assign w_grp    = r_op[7:6];
   assign w_bitno  = r_op[5:3];
   assign w_is_mem = (r_op[2:0] == 3'd6);
   assign w_mask   = 8'b1 << w_bitno;
   assign w_accept = cb_valid && (r_state == IDLE);

   always_comb begin
      case (w_grp)
         2'b00:   w_result = alu_r;
         2'b10:   w_result = r_operand & ~w_mask;
         2'b11:   w_result = r_operand | w_mask;
         default: w_result = r_operand;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_op      <= 8'h00;
         r_operand <= 8'h00;
         r_result  <= 8'h00;
         r_addr    <= 16'h0000;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op   <= cb_opcode;
            r_addr <= hl;
         end
         if (r_state == REG_RD)
            r_operand <= reg_rdata;
         if (r_state == MEM_RD && mem_ack)
            r_operand <= mem_rdata;
         if (r_state == EXEC)
            r_result <= w_result;
      end
   end

   always_comb begin
      w_next    = r_state;
      cb_ready  = 1'b0;
      done      = 1'b0;
      reg_we    = 1'b0;
      reg_wdata = 8'h00;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      flags_we  = 1'b0;
      flags_out = 4'h0;
      case (r_state)
         IDLE: begin
            cb_ready = 1'b1;
            if (cb_valid)
               w_next = (cb_opcode[2:0] == 3'd6) ? MEM_RD : REG_RD;
         end
         REG_RD: w_next = EXEC;
         MEM_RD: begin
            mem_rd = 1'b1;
            if (mem_ack)
               w_next = EXEC;
         end
         EXEC: begin
            // BIT only touches flags; the other groups write data back
            if (w_grp == 2'b01) begin
               flags_we  = 1'b1;
               flags_out = {~r_operand[w_bitno], 1'b0, 1'b1, flags_in[0]};
            end else begin
               if (w_grp == 2'b00) begin
                  flags_we  = 1'b1;
                  flags_out = alu_flags;
               end
               if (!w_is_mem) begin
                  reg_we    = 1'b1;
                  reg_wdata = w_result;
               end
            end
            w_next = (w_is_mem && w_grp != 2'b01) ? MEM_WR : DONE;
         end
         MEM_WR: begin
            mem_wr = 1'b1;
            if (mem_ack)
               w_next = DONE;
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign reg_sel   = r_op[2:0];
   assign mem_addr  = r_addr;
   assign mem_wdata = r_result;
   assign alu_op    = {1'b1, r_op[5:3]};
   assign alu_lhs   = r_operand;

endmodule

// File: tb/tb_cb_exec.sv
// Directed bench for cb_exec: drives hand-picked opcodes and bus/ALU responses
// and compares strobes and data against hand-computed values.
module tb_cb_exec;

   logic        clk = 1'b0;
   logic        rst;
   logic        cb_valid;
   logic [7:0]  cb_opcode;
   logic        cb_ready;
   logic        done;
   logic [2:0]  reg_sel;
   logic [7:0]  reg_rdata;
   logic        reg_we;
   logic [7:0]  reg_wdata;
   logic [15:0] hl;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;
   logic [3:0]  alu_op;
   logic [7:0]  alu_lhs;
   logic [7:0]  alu_r;
   logic [3:0]  alu_flags;
   logic [3:0]  flags_in;
   logic        flags_we;
   logic [3:0]  flags_out;

   int errors = 0;
   int checks = 0;

   cb_exec dut (
      .clk(clk), .rst(rst),
      .cb_valid(cb_valid), .cb_opcode(cb_opcode), .cb_ready(cb_ready), .done(done),
      .reg_sel(reg_sel), .reg_rdata(reg_rdata), .reg_we(reg_we), .reg_wdata(reg_wdata),
      .hl(hl), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .alu_op(alu_op), .alu_lhs(alu_lhs), .alu_r(alu_r), .alu_flags(alu_flags),
      .flags_in(flags_in), .flags_we(flags_we), .flags_out(flags_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   initial begin
      rst = 1'b1; cb_valid = 1'b0; cb_opcode = 8'h00; reg_rdata = 8'h00;
      hl = 16'h0000; mem_rdata = 8'h00; mem_ack = 1'b0; alu_r = 8'h00;
      alu_flags = 4'h0; flags_in = 4'h0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_ready",  16'(cb_ready),  16'h1);
      chk("rst_done",   16'(done),      16'h0);
      chk("rst_strobe", 16'({reg_we, mem_rd, mem_wr, flags_we}), 16'h0);
      chk("rst_addr",   mem_addr,       16'h0000);
      chk("rst_data",   16'({reg_wdata, mem_wdata}), 16'h0000);
      chk("rst_lhs",    16'(alu_lhs),   16'h00);

      // RLC B with 0x85
      cb_valid = 1'b1; cb_opcode = 8'h00; reg_rdata = 8'h85; alu_r = 8'h0B; alu_flags = 4'b0001;
      tick(); cb_valid = 1'b0;
      chk("t1_ready_rr", 16'(cb_ready), 16'h0);
      chk("t1_we_rr",    16'(reg_we),   16'h0);
      tick();
      chk("t1_we",      16'(reg_we),    16'h1);
      chk("t1_wdata",   16'(reg_wdata), 16'h0B);
      chk("t1_fwe",     16'(flags_we),  16'h1);
      chk("t1_fout",    16'(flags_out), 16'h1);
      chk("t1_aluop",   16'(alu_op),    16'h8);
      chk("t1_lhs",     16'(alu_lhs),   16'h85);
      tick();
      chk("t1_done",    16'(done),      16'h1);
      chk("t1_we_off",  16'(reg_we),    16'h0);
      tick();
      chk("t1_idle",    16'(cb_ready),  16'h1);
      chk("t1_done_off",16'(done),      16'h0);

      // SWAP A with 0xF0, then with 0x00
      cb_valid = 1'b1; cb_opcode = 8'h37; reg_rdata = 8'hF0; alu_r = 8'h0F; alu_flags = 4'b0000;
      tick(); cb_valid = 1'b0;
      chk("t2_sel",     16'(reg_sel),   16'h7);
      tick();
      chk("t2_aluop",   16'(alu_op),    16'hE);
      chk("t2_wdata",   16'(reg_wdata), 16'h0F);
      chk("t2_fout",    16'(flags_out), 16'h0);
      tick(); tick();
      cb_valid = 1'b1; reg_rdata = 8'h00; alu_r = 8'h00; alu_flags = 4'b1000;
      tick(); cb_valid = 1'b0;
      tick();
      chk("t2b_wdata",  16'(reg_wdata), 16'h00);
      chk("t2b_fout",   16'(flags_out), 16'h8);
      tick(); tick();

      // BIT 7,(HL) with two read wait cycles
      cb_valid = 1'b1; cb_opcode = 8'h7E; hl = 16'hC000; flags_in = 4'b0001;
      alu_r = 8'hAA; alu_flags = 4'b1111;
      tick(); cb_valid = 1'b0; hl = 16'h1234;
      chk("t3_rd1",     16'(mem_rd),    16'h1);
      chk("t3_addr",    mem_addr,       16'hC000);
      tick();
      chk("t3_rd2",     16'(mem_rd),    16'h1);
      tick();
      chk("t3_rd3",     16'(mem_rd),    16'h1);
      mem_ack = 1'b1; mem_rdata = 8'h7F;
      tick(); mem_ack = 1'b0;
      chk("t3_rd_off",  16'(mem_rd),    16'h0);
      chk("t3_fwe",     16'(flags_we),  16'h1);
      chk("t3_fout",    16'(flags_out), 16'hB);
      chk("t3_nowr",    16'({mem_wr, reg_we}), 16'h0);
      tick();
      chk("t3_done",    16'(done),      16'h1);
      chk("t3_nowr2",   16'(mem_wr),    16'h0);
      tick();
      flags_in = 4'b0000;

      // SET 0,(HL) with immediate acks; done four cycles after accept
      cb_valid = 1'b1; cb_opcode = 8'hC6; hl = 16'hD123; mem_rdata = 8'h10; mem_ack = 1'b1;
      tick(); cb_valid = 1'b0;
      chk("t4_rd",      16'(mem_rd),    16'h1);
      tick();
      chk("t4_fwe",     16'(flags_we),  16'h0);
      chk("t4_we",      16'(reg_we),    16'h0);
      tick();
      chk("t4_wr",      16'(mem_wr),    16'h1);
      chk("t4_wdata",   16'(mem_wdata), 16'h11);
      chk("t4_addr",    mem_addr,       16'hD123);
      chk("t4_fwe2",    16'(flags_we),  16'h0);
      tick();
      chk("t4_done",    16'(done),      16'h1);
      chk("t4_wr_off",  16'(mem_wr),    16'h0);
      mem_ack = 1'b0;
      tick();

      // RES 0,(HL) abandoned by reset during an unacknowledged write
      cb_valid = 1'b1; cb_opcode = 8'h86; hl = 16'hBEEF; mem_rdata = 8'h81; mem_ack = 1'b1;
      tick(); cb_valid = 1'b0;
      tick(); mem_ack = 1'b0;
      tick();
      chk("t5_wr",      16'(mem_wr),    16'h1);
      chk("t5_wdata",   16'(mem_wdata), 16'h80);
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("t5_wr_off",  16'(mem_wr),    16'h0);
      chk("t5_ready",   16'(cb_ready),  16'h1);
      chk("t5_nodone",  16'(done),      16'h0);
      chk("t5_addr",    mem_addr,       16'h0000);
      tick();
      chk("t5_nodone2", 16'(done),      16'h0);

      // RL C with cb_valid held high across two executions
      cb_valid = 1'b1; cb_opcode = 8'h11; flags_in = 4'b0001; reg_rdata = 8'h80;
      alu_r = 8'h01; alu_flags = 4'b0001;
      for (int n = 0; n < 2; n++) begin
         tick();
         chk("t6_ready_rr", 16'(cb_ready), 16'h0);
         chk("t6_done_rr",  16'(done),     16'h0);
         tick();
         chk("t6_ready_ex", 16'(cb_ready), 16'h0);
         chk("t6_we",       16'(reg_we),   16'h1);
         chk("t6_wdata",    16'(reg_wdata), 16'h01);
         chk("t6_fout",     16'(flags_out), 16'h1);
         chk("t6_aluop",    16'(alu_op),   16'hA);
         tick();
         chk("t6_ready_dn", 16'(cb_ready), 16'h0);
         chk("t6_done",     16'(done),     16'h1);
         chk("t6_we_off",   16'(reg_we),   16'h0);
         tick();
         chk("t6_ready_id", 16'(cb_ready), 16'h1);
      end
      cb_valid = 1'b0;
      tick();
      chk("t6_end_we",    16'(reg_we),   16'h0);
      tick(); tick(); tick();
      chk("t6_quiet",     16'({done, reg_we, cb_ready}), 16'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
